// File: rtl/barra.sv
// Breakout paddle controller: debounced buttons move the bar on a frame tick, hits are counted, IDLE/PLAY/OVER sequencing.
// Latency: x_bar updates 1 cycle after tick; hit_count/hit_flash 1 cycle after the registered hit_bar edge; reset acts at once.
// Backpressure: none; level inputs are sampled every cycle. Optional macro BARRA_ACCEL_EN enables a fast step for long holds.
module barra #(
   parameter int H_BAR    = 8,
   parameter int W_BAR    = 64,
   parameter int Y_BAR    = 448,
   parameter int X_HOME   = 320,
   parameter int STEP     = 4,
   parameter int TICK_DIV = 416667,
   parameter int DEB_CYC  = 250000,
   parameter int FLASH_TK = 8
`ifdef BARRA_ACCEL_EN
   , parameter int HOLD_TK = 16
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       hit_bar,
   input  logic       endgame,
   output logic [9:0] x_bar,
   output logic [9:0] y_bar,
   output logic       playing,
   output logic [7:0] hit_count,
   output logic       hit_flash
);

   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam int FW = $clog2(FLASH_TK + 1);
   // keep the whole bar on the 480-line screen even for odd geometry
   localparam int Y_POS = (Y_BAR + H_BAR > 479) ? (479 - H_BAR) : Y_BAR;
   localparam logic [10:0] LIM_L = 11'(W_BAR);
   localparam logic [10:0] LIM_R = 11'(640 - W_BAR);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

   state_t        state, state_nx;
   logic [2:0]    btn_raw, sync1, sync2, deb;
   logic [DW-1:0] deb_cnt [3];
   logic          start_q, start_rise;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          hit_q, hit_rise, go_idle;
   logic [FW-1:0] flash_cnt;
   logic          left_only, right_only;
   logic [10:0]   x_wide, step;
   logic [9:0]    x_next;

   // bit 0 = left, bit 1 = right, bit 2 = start
   assign btn_raw    = {start, btn_right, btn_left};
   assign left_only  = deb[0] & ~deb[1];
   assign right_only = deb[1] & ~deb[0];
   assign start_rise = deb[2] & ~start_q;
   assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
   assign hit_rise   = hit_bar & ~hit_q;
   assign go_idle    = (state == OVER) && start_rise;
   assign playing    = (state == PLAY);
   assign y_bar      = 10'(Y_POS);
   assign x_wide     = {1'b0, x_bar};

   // two-flop synchronisers, then a debounced level that only follows after DEB_CYC differing samples
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         deb     <= '0;
         start_q <= 1'b0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         start_q <= deb[2];
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // free-running frame tick divider, runs in every state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) tick_cnt <= '0;
      else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

`ifdef BARRA_ACCEL_EN
   localparam int HW = $clog2(HOLD_TK + 1);
   logic [HW-1:0] hold_cnt;
   logic          hold_dir;

   assign step = (hold_cnt == HW'(HOLD_TK)) ? 11'(2 * STEP) : 11'(STEP);

   // counts move ticks with one direction held; release, both or reversal start over
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         hold_dir <= 1'b0;
      end else if ((state != PLAY) || !(left_only || right_only)) begin
         hold_cnt <= '0;
      end else begin
         hold_dir <= right_only;
         if (right_only != hold_dir)                   hold_cnt <= tick ? HW'(1) : '0;
         else if (tick && hold_cnt != HW'(HOLD_TK))    hold_cnt <= hold_cnt + 1'b1;
      end
   end
`else
   assign step = 11'(STEP);
`endif

   // next bar position, compared in 11 bits so the clamp never sees a 10-bit wrap
   always_comb begin
      x_next = x_bar;
      if (left_only)
         x_next = (x_wide < LIM_L + step) ? 10'(LIM_L) : 10'(x_wide - step);
      else if (right_only)
         x_next = (x_wide > LIM_R - step) ? 10'(LIM_R) : 10'(x_wide + step);
   end

   // game state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // game sequencing: endgame only matters in PLAY
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_rise) state_nx = PLAY;
         PLAY:    if (endgame)    state_nx = OVER;
         OVER:    if (start_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // bar position, hit counter and flash timer; OVER freezes x and count but lets the flash decay
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_bar     <= 10'(X_HOME);
         hit_count <= '0;
         hit_flash <= 1'b0;
         flash_cnt <= '0;
         hit_q     <= 1'b0;
      end else begin
         hit_q <= hit_bar;
         if (go_idle) begin
            x_bar     <= 10'(X_HOME);
            hit_count <= '0;
            hit_flash <= 1'b0;
            flash_cnt <= '0;
         end else begin
            if ((state == PLAY) && tick) x_bar <= x_next;
            if ((state == PLAY) && hit_rise) begin
               if (hit_count != 8'hFF) hit_count <= hit_count + 1'b1;
               hit_flash <= 1'b1;
               flash_cnt <= FW'(FLASH_TK);
            end else if (tick && (flash_cnt != '0)) begin
               flash_cnt <= flash_cnt - 1'b1;
               if (flash_cnt == FW'(1)) hit_flash <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_barra.sv
// Directed bench for barra with fast timing (TICK_DIV=4, DEB_CYC=2, FLASH_TK=2, HOLD_TK=3).
// A second instance homes at 322 so the bar can land exactly on 66 and 574 next to the limits.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_barra;

   logic       clock = 1'b0, reset = 1'b1, start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       hit_bar = 1'b0, endgame = 1'b0;
   logic [9:0] x_bar, y_bar, ox_bar, oy_bar;
   logic       playing, hit_flash, oplaying, ohit_flash;
   logic [7:0] hit_count, ohit_count;
   int         errors = 0, checks = 0;

`ifdef BARRA_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   always #5 clock = ~clock;

   barra #(.TICK_DIV(4), .DEB_CYC(2), .FLASH_TK(2)
`ifdef BARRA_ACCEL_EN
      , .HOLD_TK(3)
`endif
   ) dut (
      .clock(clock), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
      .hit_bar(hit_bar), .endgame(endgame), .x_bar(x_bar), .y_bar(y_bar), .playing(playing),
      .hit_count(hit_count), .hit_flash(hit_flash)
   );

   barra #(.X_HOME(322), .TICK_DIV(4), .DEB_CYC(2), .FLASH_TK(2)
`ifdef BARRA_ACCEL_EN
      , .HOLD_TK(3)
`endif
   ) dut_odd (
      .clock(clock), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
      .hit_bar(hit_bar), .endgame(endgame), .x_bar(ox_bar), .y_bar(oy_bar), .playing(oplaying),
      .hit_count(ohit_count), .hit_flash(ohit_flash)
   );

   // expected bar position after one move tick; k = ticks the button has been held before this one
   function automatic logic [9:0] mv(input logic [9:0] x, input logic right, input int k);
      int s, r;
      s = (ACCEL && k >= 3) ? 8 : 4;
      if (right) r = (int'(x) + s > 576) ? 576 : int'(x) + s;
      else       r = (int'(x) - s < 64)  ? 64  : int'(x) - s;
      return 10'(r);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; hit_bar = 1'b0; endgame = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic pulse_start;
      start = 1'b1; cyc(6);
      start = 1'b0; cyc(6);
   endtask

   // waits for the first move of a held button; this locks the bench onto the tick phase
   task automatic wait_change(input logic use_odd);
      logic [9:0] x0;
      logic       seen;
      x0 = use_odd ? ox_bar : x_bar;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc(1);
         if ((use_odd ? ox_bar : x_bar) !== x0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL wait_move: x_bar stuck at %0d, required a move within 40 cycles", x0); end
   endtask

   task automatic test_reset;
      cyc(1);
      reset = 1'b0;
      cyc(1);
      checks++; if (x_bar !== 10'd320)    begin errors++; $display("FAIL reset_x: got %0d want 320", x_bar); end
      checks++; if (y_bar !== 10'd448)    begin errors++; $display("FAIL reset_y: got %0d want 448", y_bar); end
      checks++; if (playing !== 1'b0)     begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
      checks++; if (hit_count !== 8'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", hit_count); end
      checks++; if (hit_flash !== 1'b0)   begin errors++; $display("FAIL reset_flash: got %b want 0", hit_flash); end
      checks++; if (ox_bar !== 10'd322)   begin errors++; $display("FAIL reset_odd_x: got %0d want 322", ox_bar); end
      pulse_start;
      btn_right = 1'b1;
      cyc(20);
      checks++; if (!(x_bar > 10'd320)) begin errors++; $display("FAIL premove_x: got %0d want >320", x_bar); end
      #2 reset = 1'b1;
      #1;
      checks++; if (x_bar !== 10'd320)  begin errors++; $display("FAIL midreset_x: got %0d want 320", x_bar); end
      checks++; if (y_bar !== 10'd448)  begin errors++; $display("FAIL midreset_y: got %0d want 448", y_bar); end
      checks++; if (playing !== 1'b0)   begin errors++; $display("FAIL midreset_playing: got %b want 0", playing); end
      checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", hit_count); end
      btn_right = 1'b0;
      cyc(1);
      reset = 1'b0;
   endtask

   task automatic test_move_right;
      logic [9:0] e, xs;
      do_reset;
      pulse_start;
      checks++; if (playing !== 1'b1)  begin errors++; $display("FAIL start_playing: got %b want 1", playing); end
      checks++; if (x_bar !== 10'd320) begin errors++; $display("FAIL start_x: got %0d want 320", x_bar); end
      btn_right = 1'b1;
      wait_change(1'b0);
      e = mv(10'd320, 1'b1, 0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin cyc(4); e = mv(e, 1'b1, k); end
         checks++; if (x_bar !== e) begin errors++; $display("FAIL right_tick%0d: got %0d want %0d", k, x_bar, e); end
      end
`ifndef BARRA_ACCEL_EN
      checks++; if (x_bar !== 10'd360) begin errors++; $display("FAIL right_10ticks: got %0d want 360", x_bar); end
`endif
      btn_right = 1'b0;
      cyc(12);
      xs = x_bar;
      cyc(12);
      checks++; if (x_bar !== xs) begin errors++; $display("FAIL release_hold: got %0d want %0d", x_bar, xs); end
   endtask

   task automatic test_clamp;
      logic [9:0] e;
      do_reset;
      pulse_start;
      btn_right = 1'b1;
      wait_change(1'b1);
      e = mv(10'd322, 1'b1, 0);
      for (int k = 0; k < 66; k++) begin
         if (k > 0) begin cyc(4); e = mv(e, 1'b1, k); end
         checks++; if (ox_bar !== e) begin errors++; $display("FAIL clamp_right_tick%0d: got %0d want %0d", k, ox_bar, e); end
      end
      checks++; if (ox_bar !== 10'd576) begin errors++; $display("FAIL right_limit: got %0d want 576", ox_bar); end
      do_reset;
      pulse_start;
      btn_left = 1'b1;
      wait_change(1'b1);
      e = mv(10'd322, 1'b0, 0);
      for (int k = 0; k < 67; k++) begin
         if (k > 0) begin cyc(4); e = mv(e, 1'b0, k); end
         checks++; if (ox_bar !== e) begin errors++; $display("FAIL clamp_left_tick%0d: got %0d want %0d", k, ox_bar, e); end
      end
      checks++; if (ox_bar !== 10'd64) begin errors++; $display("FAIL left_limit_odd: got %0d want 64", ox_bar); end
      checks++; if (x_bar !== 10'd64)  begin errors++; $display("FAIL left_limit: got %0d want 64", x_bar); end
      btn_left = 1'b0;
   endtask

   task automatic test_hit;
      do_reset;
      pulse_start;
      hit_bar = 1'b1;
      cyc(1);
      checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL hit_first: got %0d want 1", hit_count); end
      checks++; if (hit_flash !== 1'b1) begin errors++; $display("FAIL flash_on: got %b want 1", hit_flash); end
      cyc(4);
      checks++; if (hit_flash !== 1'b1) begin errors++; $display("FAIL flash_still: got %b want 1", hit_flash); end
      cyc(4);
      checks++; if (hit_flash !== 1'b0) begin errors++; $display("FAIL flash_off: got %b want 0", hit_flash); end
      cyc(11);
      checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL hit_level: got %0d want 1", hit_count); end
      hit_bar = 1'b0;
      cyc(1);
      for (int i = 0; i < 300; i++) begin
         hit_bar = 1'b1; cyc(1);
         hit_bar = 1'b0; cyc(1);
         if (i == 253) begin
            checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL hit_255: got %0d want 255", hit_count); end
         end
      end
      checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL hit_saturate: got %0d want 255", hit_count); end
   endtask

   task automatic test_over;
      logic [9:0] xs;
      do_reset;
      pulse_start;
      btn_right = 1'b1;
      wait_change(1'b0);
      cyc(8);
      btn_right = 1'b0;
      cyc(12);
      xs = x_bar;
      checks++; if (!(xs > 10'd320)) begin errors++; $display("FAIL over_premove: got %0d want >320", xs); end
      hit_bar = 1'b1; endgame = 1'b1;
      cyc(1);
      checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL over_hit: got %0d want 1", hit_count); end
      checks++; if (playing !== 1'b0)   begin errors++; $display("FAIL over_playing: got %b want 0", playing); end
      checks++; if (hit_flash !== 1'b1) begin errors++; $display("FAIL over_flash: got %b want 1", hit_flash); end
      btn_left = 1'b1;
      cyc(20);
      checks++; if (x_bar !== xs)       begin errors++; $display("FAIL over_frozen: got %0d want %0d", x_bar, xs); end
      checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL over_count_held: got %0d want 1", hit_count); end
      checks++; if (hit_flash !== 1'b0) begin errors++; $display("FAIL over_flash_decay: got %b want 0", hit_flash); end
      btn_left = 1'b0; hit_bar = 1'b0; endgame = 1'b0;
      cyc(12);
      pulse_start;
      checks++; if (x_bar !== 10'd320)  begin errors++; $display("FAIL idle_x: got %0d want 320", x_bar); end
      checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL idle_count: got %0d want 0", hit_count); end
      checks++; if (playing !== 1'b0)   begin errors++; $display("FAIL idle_playing: got %b want 0", playing); end
      pulse_start;
      checks++; if (playing !== 1'b1)   begin errors++; $display("FAIL replay_playing: got %b want 1", playing); end
      btn_right = 1'b1;
      cyc(1);
      btn_right = 1'b0;
      cyc(16);
      checks++; if (x_bar !== 10'd320)  begin errors++; $display("FAIL glitch_x: got %0d want 320", x_bar); end
   endtask

`ifdef BARRA_ACCEL_EN
   task automatic test_accel;
      logic [9:0] x0;
      do_reset;
      pulse_start;
      btn_right = 1'b1;
      wait_change(1'b0);
      checks++; if (x_bar !== 10'd324) begin errors++; $display("FAIL accel_t1: got %0d want 324", x_bar); end
      cyc(4);
      checks++; if (x_bar !== 10'd328) begin errors++; $display("FAIL accel_t2: got %0d want 328", x_bar); end
      cyc(4);
      checks++; if (x_bar !== 10'd332) begin errors++; $display("FAIL accel_t3: got %0d want 332", x_bar); end
      cyc(4);
      checks++; if (x_bar !== 10'd340) begin errors++; $display("FAIL accel_t4: got %0d want 340", x_bar); end
      cyc(4);
      checks++; if (x_bar !== 10'd348) begin errors++; $display("FAIL accel_t5: got %0d want 348", x_bar); end
      btn_right = 1'b0;
      cyc(12);
      x0 = x_bar;
      btn_right = 1'b1;
      wait_change(1'b0);
      checks++; if (x_bar !== x0 + 10'd4) begin errors++; $display("FAIL accel_release: got %0d want %0d", x_bar, x0 + 10'd4); end
      btn_right = 1'b0;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_move_right;
      test_clamp;
      test_hit;
      test_over;
`ifdef BARRA_ACCEL_EN
      test_accel;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
